fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
Shares one fp_add instance between N_REQ requesters, e.g. per-antenna complex-MAC lanes. It round-robin arbitrates valid/ready operand requests and drives the adder's operand inputs. A tag pipeline matching the adder latency routes each sum back to the requester that issued it. Each requester has a one-entry result slot, reserved at issue, because fp_add has no stall input.

Parameters:
N_REQ, 4, number of requesters (>=2)
I_EXP, 8, exponent width, passed through to fp_add
I_MNT, 23, mantissa width
I_DATA, I_EXP+I_MNT+1, operand/result width
ADD_LAT, 1, cycles from operands presented on add_a/add_b to add_result valid (fp_add = 1)
CNT_W, 16, width of issue counter
(localparam IDX_W = max(1, $clog2(N_REQ)))

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  N_REQ  per-requester operand valid
req_a  in  N_REQ*I_DATA  operand A, requester i at [i*I_DATA +: I_DATA]
req_b  in  N_REQ*I_DATA  operand B, same packing
req_ready  out  N_REQ  one-hot or zero; grant this cycle
add_a  out  I_DATA  to fp_add idataA
add_b  out  I_DATA  to fp_add idataB
add_result  in  I_DATA  from fp_add odata
rsp_valid  out  N_REQ  result slot i holds a result
rsp_data  out  N_REQ*I_DATA  result slot contents, same packing
rsp_ready  in  N_REQ  requester i consumes its slot
issue_cnt  out  CNT_W  saturating count of issued additions
idle  out  1  no slot reserved and nothing in flight

Behaviour:
- Reset values (async assert): rsp_valid=0, rsp_data=0, issue_cnt=0, rr_ptr=0, slot_busy=0, tag pipeline valids=0. Combinational outputs therefore read req_ready=0, add_a=add_b=0 and idle=1 while reset is held.
- Eligibility: elig[i] = req_valid[i] & ~slot_busy[i].
  - slot_busy[i] is set at the grant edge.
  - It clears at the edge where rsp_valid[i]&rsp_ready[i].
  - There is no same-cycle bypass: a slot freed at edge t is eligible from cycle t+1.
- Arbitration (combinational):
  - Winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = onehot(winner) when any elig, else 0.
  - A handshake occurs when req_valid[i]&req_ready[i] (always true for a granted index).
- rr_ptr update: on a grant to w, rr_ptr <= (w+1) mod N_REQ, wrapping N_REQ-1 -> 0. With no grant, rr_ptr holds.
- Issue:
  - add_a/add_b = winner's req_a/req_b in the grant cycle, combinationally. fp_add registers them.
  - With no grant, add_a=add_b=0; fp_add returns 0, which is ignored.
- Tag pipeline:
  - ADD_LAT-deep shift register of {valid, idx}. Stage 0 is loaded with {grant, winner} each edge.
  - Last stage valid in cycle t+ADD_LAT (t = grant cycle): at that edge rsp_data[idx] <= add_result and rsp_valid[idx] <= 1.
  - Issue-to-rsp_valid latency = ADD_LAT+1 cycles.
- Response:
  - rsp_valid[i] stays high, and rsp_data stable, until rsp_ready[i] is sampled high. The edge then clears rsp_valid[i] and slot_busy[i].
  - rsp_ready while rsp_valid=0 is ignored.
  - A writeback to slot i cannot coincide with rsp_valid[i]=1, because slot_busy blocks re-issue; the verifier asserts this.
- Simultaneous events are independent per slot: a grant to i, writeback to j and consume of k happen in the same cycle.
- Throughput:
  - Per requester: one op per ADD_LAT+2 cycles when rsp_ready is held high.
  - Aggregate: one issue per cycle when N_REQ >= ADD_LAT+2.
- issue_cnt increments on each grant and saturates at 2^CNT_W-1 (no wrap).
- idle = ~|slot_busy (in-flight ops are covered by slot_busy).
- Reset mid-operation: in-flight results are discarded and all slots are freed. fp_add's registered state is harmless because tag valids are cleared.
- Operands are passed unmodified. Zero/denormal handling belongs to fp_add.

Test Plan:
- Single op: req_valid=0001, A=0x3F800000 (1.0), B=0x40000000 (2.0) -> req_ready=0001 in cycle 0, rsp_valid[0]=1 in cycle 2 with rsp_data[0]=0x40400000, issue_cnt=1.
- Round-robin: all four req_valid high, rsp_ready=1111 -> grants 0,1,2,3,0,1,... one per cycle. A requester is never granted while its slot is busy; rr_ptr wraps 3->0.
- Backpressure: requester 2 valid continuously with rsp_ready[2]=0 -> exactly one grant; rsp_valid[2] is held with stable data; no second req_ready[2] until the cycle after rsp_ready[2] is pulsed.
- Sign cancel: A=0x40A00000 (5.0), B=0xC0A00000 (-5.0) from requester 1, A=0x3F800000, B=0xBF000000 from requester 3 in the next cycle -> each slot receives fp_add's result for its own operands in issue order. No cross-routing.
- Counter saturation with CNT_W=4: 20 issues -> issue_cnt reaches 15 and stays there.
- Async reset asserted one cycle after issue, mid-flight -> rsp_valid=0, idle=1, rr_ptr=0 immediately. After release, no stale result appears, and a new request is served with ADD_LAT+1 latency.

Source files
------------

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin shares one pipelined fp_add between N_REQ
//               requesters. The winner's operands are driven straight to the
//               adder. A tag pipeline of depth ADD_LAT steers each sum back to
//               the one-entry result slot of the requester that issued it.
//               The slot is reserved at grant time because fp_add cannot stall.
// Ports       : clk, reset        - clock and asynchronous active-high reset
//               req_valid/a/b     - per-requester operand handshake (packed)
//               req_ready         - one-hot grant for this cycle, or zero
//               add_a/add_b       - operands to fp_add
//               add_result        - sum from fp_add, ADD_LAT cycles later
//               rsp_valid/data    - per-requester result slots (packed)
//               rsp_ready         - requester consumes its slot
//               issue_cnt         - saturating count of issued additions
//               idle              - no slot reserved, nothing in flight
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
  parameter int N_REQ   = 4,
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int ADD_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*I_DATA-1:0]   req_a,
  input  logic [N_REQ*I_DATA-1:0]   req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [I_DATA-1:0]         add_a,
  output logic [I_DATA-1:0]         add_b,
  input  logic [I_DATA-1:0]         add_result,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [N_REQ*I_DATA-1:0]   rsp_data,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [CNT_W-1:0]          issue_cnt,
  output logic                      idle
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [N_REQ-1:0] slot_busy;
  logic [N_REQ-1:0] elig;
  logic             grant;
  logic [IDX_W-1:0] winner;

  // Tag pipeline: stage 0 is loaded at the grant edge, the last stage is valid
  // in the cycle the matching sum sits on add_result.
  logic [ADD_LAT-1:0] tag_vld;
  logic [IDX_W-1:0]   tag_idx [ADD_LAT];
  logic               wb_vld;
  logic [IDX_W-1:0]   wb_idx;

  // (base + off) mod N_REQ for off in [0, N_REQ)
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  // A busy slot blocks re-issue until its result has been consumed; the slot
  // freed at an edge becomes eligible only from the following cycle.
  assign elig = req_valid & ~slot_busy;

  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant && elig[rot_idx(rr_ptr, k)]) begin
        grant  = 1'b1;
        winner = rot_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
      add_a = req_a[int'(winner)*I_DATA +: I_DATA];
      add_b = req_b[int'(winner)*I_DATA +: I_DATA];
    end
  end

  assign wb_vld = tag_vld[ADD_LAT-1];
  assign wb_idx = tag_idx[ADD_LAT-1];
  assign idle   = ~|slot_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      issue_cnt <= '0;
      tag_vld   <= '0;
      for (int s = 0; s < ADD_LAT; s++) tag_idx[s] <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= rot_idx(winner, 1);
        if (issue_cnt != {CNT_W{1'b1}}) issue_cnt <= issue_cnt + CNT_W'(1);
      end
      tag_vld[0] <= grant;
      tag_idx[0] <= winner;
      for (int s = 1; s < ADD_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
    end
  end

  // Per-slot state. Grant, writeback and consume are independent across
  // slots. A grant to slot i cannot coincide with its consume (grant needs a
  // free slot, consume needs a valid one). A writeback cannot land on a valid
  // slot, because the slot stays busy until consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_busy <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (grant && (int'(winner) == i)) begin
          slot_busy[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          slot_busy[i] <= 1'b0;
        end

        if (wb_vld && (int'(wb_idx) == i)) begin
          rsp_valid[i]                   <= 1'b1;
          rsp_data[i*I_DATA +: I_DATA]   <= add_result;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Directed self-checking bench for fp_add_arbiter (4 requesters,
//               single precision, 4-bit issue counter). A one-cycle registered
//               stand-in for fp_add returns the exact IEEE sums for the float
//               vectors used here, and a plain integer sum for other operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;
  localparam int CW  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_result;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_data;
  logic [N-1:0]   rsp_ready;
  logic [CW-1:0]  issue_cnt;
  logic           idle;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(
    .N_REQ(N), .I_EXP(8), .I_MNT(23), .I_DATA(W), .ADD_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .issue_cnt(issue_cnt), .idle(idle)
  );

  // fp_add stand-in: registered, latency 1
  function automatic logic [W-1:0] fp_add_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h40A0_0000 && b == 32'hC0A0_0000) return 32'h0000_0000;
    if (a == 32'h3F80_0000 && b == 32'hBF00_0000) return 32'h3F00_0000;
    return a + b;
  endfunction

  always_ff @(posedge clk) add_result <= fp_add_ref(add_a, add_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] slot(input int i);
    return rsp_data[i*W +: W];
  endfunction

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    repeat (2) tick;

    // reset state
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_add_a",     add_a,          32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data0", slot(0),        32'h0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'h0);
    check("rst_idle",      32'(idle),      32'h1);
    reset = 1'b0;

    // single op: 1.0 + 2.0 from requester 0
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b0001;
    settle;
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_add_a", add_a,          32'h3F80_0000);
    check("single_add_b", add_b,          32'h4000_0000);
    tick;
    req_valid = '0;
    settle;
    check("single_c1_rsp_valid", 32'(rsp_valid), 32'h0);
    check("single_c1_issue_cnt", 32'(issue_cnt), 32'h1);
    check("single_c1_idle",      32'(idle),      32'h0);
    tick;
    settle;
    check("single_c2_rsp_valid", 32'(rsp_valid), 32'h1);
    check("single_c2_data",      slot(0),        32'h4040_0000);
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = '0;
    settle;
    check("single_consumed", 32'(rsp_valid), 32'h0);
    check("single_idle",     32'(idle),      32'h1);

    // round robin: pointer starts at 1 after the single op
    for (int i = 0; i < N; i++) set_op(i, 32'(256 * (i + 1)), 32'(i + 1));
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle;
      check($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(1 << ((1 + k) % 4)));
      if (k >= 2) begin
        check($sformatf("rr_rsp_valid_%0d", k), 32'(rsp_valid), 32'(1 << ((k - 1) % 4)));
        check($sformatf("rr_rsp_data_%0d", k), slot((k - 1) % 4),
              32'(257 * (((k - 1) % 4) + 1)));
      end
      tick;
    end
    req_valid = '0;
    repeat (3) tick;
    check("rr_drain_idle", 32'(idle),      32'h1);
    check("rr_issue_cnt",  32'(issue_cnt), 32'd9);

    // backpressure on requester 2 (pointer now 1)
    rsp_ready = '0;
    set_op(2, 32'h0000_0200, 32'h0000_0022);
    req_valid = 4'b0100;
    settle;
    check("bp_grant", 32'(req_ready), 32'h4);
    tick;
    for (int c = 1; c <= 4; c++) begin
      settle;
      check($sformatf("bp_no_regrant_%0d", c), 32'(req_ready), 32'h0);
      if (c >= 2) begin
        check($sformatf("bp_hold_valid_%0d", c), 32'(rsp_valid), 32'h4);
        check($sformatf("bp_hold_data_%0d", c), slot(2), 32'h0000_0222);
      end
      tick;
    end
    rsp_ready = 4'b0100;
    settle;
    check("bp_no_bypass", 32'(req_ready), 32'h0);
    tick;
    rsp_ready = '0;
    settle;
    check("bp_consumed",  32'(rsp_valid), 32'h0);
    check("bp_regrant",   32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    rsp_ready = 4'b1111;
    repeat (3) tick;
    check("bp_issue_cnt", 32'(issue_cnt), 32'd11);
    check("bp_idle",      32'(idle),      32'h1);

    // sign cancel / routing: requester 1 then requester 3
    rsp_ready = '0;
    set_op(1, 32'h40A0_0000, 32'hC0A0_0000);
    set_op(3, 32'h3F80_0000, 32'hBF00_0000);
    req_valid = 4'b0010;
    settle;
    check("sc_grant1", 32'(req_ready), 32'h2);
    tick;
    req_valid = 4'b1000;
    settle;
    check("sc_grant3", 32'(req_ready), 32'h8);
    tick;
    req_valid = '0;
    settle;
    check("sc_rsp_valid_a", 32'(rsp_valid), 32'h2);
    check("sc_slot1",       slot(1),        32'h0);
    tick;
    settle;
    check("sc_rsp_valid_b", 32'(rsp_valid), 32'hA);
    check("sc_slot3",       slot(3),        32'h3F00_0000);
    check("sc_slot1_held",  slot(1),        32'h0);
    rsp_ready = 4'b1111;
    tick;
    rsp_ready = '0;
    settle;
    check("sc_idle",      32'(idle),      32'h1);
    check("sc_issue_cnt", 32'(issue_cnt), 32'd13);

    // counter saturation: 8 more issues take the 4-bit counter past 15
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick;
      settle;
      check($sformatf("sat_cnt_%0d", k), 32'(issue_cnt), (14 + k > 15) ? 32'd15 : 32'(14 + k));
    end
    req_valid = '0;
    repeat (3) tick;
    check("sat_final", 32'(issue_cnt), 32'd15);
    check("sat_idle",  32'(idle),      32'h1);

    // async reset mid-flight
    rsp_ready = '0;
    req_valid = 4'b0010;
    settle;
    check("rst_mf_grant", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mf_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_mf_idle",      32'(idle),      32'h1);
    check("rst_mf_issue_cnt", 32'(issue_cnt), 32'h0);
    check("rst_mf_slot1",     slot(1),        32'h0);
    repeat (2) tick;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle;
      check($sformatf("rst_no_stale_%0d", c), 32'(rsp_valid), 32'h0);
      tick;
    end
    set_op(0, 32'h3F80_0000, 32'h4000_0000);
    req_valid = 4'b1111;
    settle;
    check("rst_ptr_zero", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    settle;
    check("rst_new_c1_valid", 32'(rsp_valid), 32'h0);
    tick;
    settle;
    check("rst_new_c2_valid", 32'(rsp_valid), 32'h1);
    check("rst_new_c2_data",  slot(0),        32'h4040_0000);
    check("rst_new_cnt",      32'(issue_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
